// File: rtl/sound_mixer_if.sv
// Sound source levels into the mixer, and mixed PCM plus sigma-delta DAC bits out.
// The master drives the sources and the slave (the mixer) drives the results.
interface sound_mixer_if;
    logic       ck35;
    logic       en_ts;
    logic [1:0] stereo_mode;
    logic       beeper;
    logic       tape_out;
    logic       tape_in;
    logic [7:0] covox;
    logic [7:0] ay_a0, ay_b0, ay_c0;
    logic [7:0] ay_a1, ay_b1, ay_c1;
    logic [11:0] pcm_l, pcm_r;
    logic       pcm_valid;
    logic       dac_l, dac_r;

    modport master (
        output ck35, en_ts, stereo_mode, beeper, tape_out, tape_in, covox,
               ay_a0, ay_b0, ay_c0, ay_a1, ay_b1, ay_c1,
        input  pcm_l, pcm_r, pcm_valid, dac_l, dac_r
    );

    modport slave (
        input  ck35, en_ts, stereo_mode, beeper, tape_out, tape_in, covox,
               ay_a0, ay_b0, ay_c0, ay_a1, ay_b1, ay_c1,
        output pcm_l, pcm_r, pcm_valid, dac_l, dac_r
    );
endinterface

// File: rtl/sound_mixer.sv
// Three-stage ck35-enabled mixer of AY/ULA/covox sources into 12-bit stereo PCM, with
// PCM two ck35 edges after capture; gaps in ck35 stall the pipeline, the sigma-delta DACs always run.
module sound_mixer #(
    parameter int BEEPER_W   = 384,
    parameter int TAPE_OUT_W = 64,
    parameter int TAPE_IN_W  = 32
) (
    input  logic         clk28,
    input  logic         rst,
    sound_mixer_if.slave mix
);
    localparam logic [31:0] BEEP_WV = 32'(BEEPER_W);
    localparam logic [31:0] TOUT_WV = 32'(TAPE_OUT_W);
    localparam logic [31:0] TIN_WV  = 32'(TAPE_IN_W);

    // Returns {left, right} for one AY chip in the selected layout; mode 3 falls back to ABC.
    function automatic logic [23:0] chip_pair(input logic [1:0] mode,
                                              input logic [7:0] a, b, c);
        logic [11:0] ea, eb, ec, l, r;
        ea = {4'd0, a};
        eb = {4'd0, b};
        ec = {4'd0, c};
        case (mode)
            2'd0: begin
                l = ea + eb + ec;
                r = l;
            end
            2'd2: begin
                l = (ea << 1) + ec;
                r = (eb << 1) + ec;
            end
            default: begin
                l = (ea << 1) + eb;
                r = (ec << 1) + eb;
            end
        endcase
        return {l, r};
    endfunction

    logic        s1_vld_q;
    logic [1:0]  s1_mode_q;
    logic [7:0]  s1_a0_q, s1_b0_q, s1_c0_q, s1_a1_q, s1_b1_q, s1_c1_q;
    logic        s1_beep_q, s1_tout_q, s1_tin_q;
    logic [7:0]  s1_covox_q;

    logic        s2_vld_q;
    logic [11:0] s2_l_q, s2_r_q, s2_l_d, s2_r_d;
    logic [31:0] s2_common_q, s2_common_d;

    logic [11:0] pcm_l_q, pcm_r_q, pcm_l_d, pcm_r_d;
    logic        pcm_valid_q;
    logic [12:0] acc_l_q, acc_r_q, acc_l_d, acc_r_d;
    logic        dac_l_q, dac_r_q;

    logic [23:0] pair0, pair1;
    logic [31:0] sum_l, sum_r;

    always_comb begin
        pair0       = chip_pair(s1_mode_q, s1_a0_q, s1_b0_q, s1_c0_q);
        pair1       = chip_pair(s1_mode_q, s1_a1_q, s1_b1_q, s1_c1_q);
        s2_l_d      = pair0[23:12] + pair1[23:12];
        s2_r_d      = pair0[11:0]  + pair1[11:0];
        s2_common_d = (s1_beep_q ? BEEP_WV : 32'd0) + (s1_tout_q ? TOUT_WV : 32'd0)
                    + (s1_tin_q ? TIN_WV : 32'd0) + {24'd0, s1_covox_q};
        sum_l       = {20'd0, s2_l_q} + s2_common_q;
        sum_r       = {20'd0, s2_r_q} + s2_common_q;
        pcm_l_d     = (sum_l > 32'd4095) ? 12'hFFF : sum_l[11:0];
        pcm_r_d     = (sum_r > 32'd4095) ? 12'hFFF : sum_r[11:0];
        acc_l_d     = {1'b0, acc_l_q[11:0]} + {1'b0, pcm_l_q};
        acc_r_d     = {1'b0, acc_r_q[11:0]} + {1'b0, pcm_r_q};
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_mode_q   <= 2'd0;
            s1_a0_q     <= 8'd0;
            s1_b0_q     <= 8'd0;
            s1_c0_q     <= 8'd0;
            s1_a1_q     <= 8'd0;
            s1_b1_q     <= 8'd0;
            s1_c1_q     <= 8'd0;
            s1_beep_q   <= 1'b0;
            s1_tout_q   <= 1'b0;
            s1_tin_q    <= 1'b0;
            s1_covox_q  <= 8'd0;
            s2_vld_q    <= 1'b0;
            s2_l_q      <= 12'd0;
            s2_r_q      <= 12'd0;
            s2_common_q <= 32'd0;
            pcm_l_q     <= 12'd0;
            pcm_r_q     <= 12'd0;
            pcm_valid_q <= 1'b0;
            acc_l_q     <= 13'd0;
            acc_r_q     <= 13'd0;
            dac_l_q     <= 1'b0;
            dac_r_q     <= 1'b0;
        end else begin
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            dac_l_q     <= acc_l_q[12];
            dac_r_q     <= acc_r_q[12];
            pcm_valid_q <= 1'b0;
            if (mix.ck35) begin
                s1_vld_q    <= 1'b1;
                s1_mode_q   <= mix.stereo_mode;
                s1_a0_q     <= mix.ay_a0;
                s1_b0_q     <= mix.ay_b0;
                s1_c0_q     <= mix.ay_c0;
                s1_a1_q     <= mix.en_ts ? mix.ay_a1 : 8'd0;
                s1_b1_q     <= mix.en_ts ? mix.ay_b1 : 8'd0;
                s1_c1_q     <= mix.en_ts ? mix.ay_c1 : 8'd0;
                s1_beep_q   <= mix.beeper;
                s1_tout_q   <= mix.tape_out;
                s1_tin_q    <= mix.tape_in;
                s1_covox_q  <= mix.covox;
                s2_vld_q    <= s1_vld_q;
                s2_l_q      <= s2_l_d;
                s2_r_q      <= s2_r_d;
                s2_common_q <= s2_common_d;
                // Only a sample that really travelled the pipeline may reach the outputs.
                if (s2_vld_q) begin
                    pcm_l_q     <= pcm_l_d;
                    pcm_r_q     <= pcm_r_d;
                    pcm_valid_q <= 1'b1;
                end
            end
        end
    end

    assign mix.pcm_l     = pcm_l_q;
    assign mix.pcm_r     = pcm_r_q;
    assign mix.pcm_valid = pcm_valid_q;
    assign mix.dac_l     = dac_l_q;
    assign mix.dac_r     = dac_r_q;
endmodule

// File: doc/sound_mixer.md
Name: sound_mixer

Overview:
Downstream consumer of the TurboSound block and the ULA sound sources. It captures the six AY channel levels, the beeper, tape and covox on each 3.5 MHz strobe and sums them into 12-bit left/right PCM using a selectable stereo layout. It then drives two first-order sigma-delta 1-bit DAC pins for the board's RC audio filters.

Parameters:
BEEPER_W, 384, weight added to both channels when beeper=1
TAPE_OUT_W, 64, weight added to both channels when tape_out=1
TAPE_IN_W, 32, weight added to both channels when tape_in=1

Ports:
clk28  input  1  28 MHz system clock; sole clock
rst  input  1  synchronous reset, active-high
ck35  input  1  one-clk28 pulse at 3.5 MHz; sample enable
en_ts  input  1  second AY enabled; when 0, ay_*1 are treated as 0
stereo_mode  input  2  0=mono, 1=ABC, 2=ACB, 3=reserved (behaves as ABC)
beeper  input  1  ULA beeper bit
tape_out  input  1  ULA tape-out bit
tape_in  input  1  tape input bit, already synchronised
covox  input  8  covox DAC byte, added to both channels
ay_a0, ay_b0, ay_c0  input  8  AY chip 0 channel levels
ay_a1, ay_b1, ay_c1  input  8  AY chip 1 channel levels
pcm_l, pcm_r  output  12  mixed unsigned PCM
pcm_valid  output  1  one-clk28 pulse when pcm_l/pcm_r update
dac_l, dac_r  output  1  sigma-delta bitstreams

Behaviour:
- Reset (rst=1 at a clk28 edge): all pipeline registers, pcm_l, pcm_r, pcm_valid, both accumulators, dac_l and dac_r go to 0. Reset overrides ck35 in the same cycle. Reset asserted mid-pipeline discards in-flight samples, and no pcm_valid fires for them.
- Stage 1, on a clk28 edge with ck35=1:
  - Register all inputs.
  - Register ay_*1 as 0 when en_ts=0.
  - Register stereo_mode.
- Stage 2, on the next ck35 edge: compute per-chip pairs (i = 0 and 1):
  - ABC: Li = 2*Ai + Bi, Ri = 2*Ci + Bi
  - ACB: Li = 2*Ai + Ci, Ri = 2*Bi + Ci
  - mono: Li = Ri = Ai + Bi + Ci
- Stage 3, on the next ck35 edge:
  - pcm_l = L0 + L1 + common, and pcm_r = R0 + R1 + common.
  - common = beeper*BEEPER_W + tape_out*TAPE_OUT_W + tape_in*TAPE_IN_W + covox.
  - pcm_valid pulses high for exactly this one clk28 cycle.
- Latency: an input captured at ck35 edge N appears on pcm_* at ck35 edge N+2. pcm_* holds between updates.
- Width: worst-case sum is 1530 + 384 + 64 + 32 + 255 = 2265, which is below 4096, so there is no wrap.
  - Internal sums are at least 12 bits wide. Intermediate truncation is not allowed.
  - If parameters are overridden such that the sum exceeds 4095, saturate at 4095.
- Sigma-delta, every clk28 cycle independent of ck35:
  - acc_x is 13 bits: acc_x <= {1'b0, acc_x[11:0]} + pcm_x.
  - dac_x <= acc_x[12] (carry out of the addition, registered).
  - Over any 4096 consecutive clk28 cycles with constant pcm_x = P, exactly P cycles have dac_x = 1.
  - pcm=0 gives a constant 0 output; pcm=4095 gives 4095 ones per 4096 cycles.
- stereo_mode and en_ts changes take effect only for samples captured after the change. There is no glitch on samples already in the pipeline.
- ck35 may be continuously high; the block then samples every clk28 cycle and behaves identically.
- Gaps between ck35 pulses only stall stages 1–3. The sigma-delta continues on held pcm values.

Test Plan:
- ABC, ay_a0=255, all other sources 0, ck35 every 8 clocks -> pcm_l=510, pcm_r=0; pcm_valid is a single clk28 pulse on the 2nd ck35 after capture.
- ACB, ay_b1=100, ay_c1=10, en_ts=1 -> pcm_l=10, pcm_r=210. Then en_ts=0 -> both outputs 0 from the sample captured after the change.
- mono, all ay_*=255, beeper=1, tape_out=1, tape_in=1, covox=255 -> pcm_l=pcm_r=2265, with no wrap.
- beeper toggling alone with mode=ABC -> pcm alternates 0/384 on both channels with 2-sample lag; no pcm_valid when ck35 is held low.
- Force pcm_l=2048 (covox/AY combination giving 2048), count dac_l over 4096 clk28 cycles after the accumulator is reset -> exactly 2048 ones, with strictly alternating pattern. pcm_l=0 -> dac_l is constant 0.
- Assert rst for one cycle while a sample is in stage 2 -> all outputs 0 the next cycle; no pcm_valid for the discarded sample; the first post-reset pcm_valid occurs 2 ck35 edges after the first post-reset capture.
